ctrl_id_stage: RTL and testbench
================================

# ctrl_id_stage

Parametrised ID-stage control unit for the pipelined RV32 core. Decodes the ID instruction into the control bundle and owns the ID/EX control register. Generates the load-use stall and sequences multi-cycle M-extension ops. Covers R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC, with registered bubble/flush/hold handling in place of a purely combinational No-op input.

## Interface
- REG_AW, 5, register-address width
- MD_LAT, 4, EX-stage latency of MUL/DIV ops in cycles; legal range 1..16
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- inst_i  in  32  instruction in IF/ID
- inst_valid_i  in  1  IF/ID holds a real instruction; 0 decodes as bubble
- hold_i  in  1  global freeze from the memory system
- flush_i  in  1  branch/jump taken; squash the ID instruction
- stall_o  out  1  hold PC and IF/ID this cycle
- ex_aluop_o  out  3  000 R, 001 I, 010 add-address (LOAD/STORE), 011 BRANCH, 100 LUI, 101 PC-add (AUIPC/JAL/JALR), 110 MULDIV
- ex_alusrc_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, ex_branch_o, ex_jump_o  out  1 each  registered control bits
- ex_rd_o  out  REG_AW  destination register of the EX instruction
- ex_md_busy_o  out  1  multi-cycle op in progress
- illegal_o  out  1  registered; the ID instruction was an unknown opcode/funct

## Operation
- Decode is combinational from inst_i[6:0], funct3 and funct7.
  - R: regwrite.
  - I: alusrc, regwrite.
  - LOAD: alusrc, regwrite, memread, memtoreg.
  - STORE: alusrc, memwrite.
  - BRANCH: branch.
  - JAL/JALR: jump, regwrite.
  - LUI/AUIPC: alusrc, regwrite.
- Unknown opcode: all-zero bundle, illegal_o=1 the next cycle.
- rs1 is used by R, I, LOAD, STORE, BRANCH and JALR. rs2 is used by R, STORE and BRANCH.
- Load-use: when ID/EX memread=1, ex_rd!=0, and ex_rd equals a used rs of inst_i (with inst_valid_i=1), then stall_o=1 and ID/EX loads a bubble.
- Bubble = all control bits 0, ex_rd=0, aluop 000.
- Multi-cycle FSM states: IDLE, BUSY.
  - IDLE->BUSY: a MULDIV op is loaded into ID/EX and MD_LAT>1. The counter loads MD_LAT-2.
  - In BUSY: stall_o=1, ex_md_busy_o=1, ID/EX held unchanged. The counter decrements each non-hold cycle.
  - BUSY->IDLE: the counter equals 0.
- Per-cycle priority, highest first:
  1. rst_i
  2. hold_i: all state frozen, stall_o=1
  3. BUSY
  4. flush_i: ID/EX <= bubble, stall_o=0
  5. load-use
  6. normal advance
- flush_i during BUSY is ignored. The branch resolves only after the MULDIV op retires, so upstream re-asserts it.
- illegal_o is cleared on the next advance.

## Timing
- Reset, synchronous: all ex_* outputs 0, ex_rd_o=0, illegal_o=0, FSM IDLE, counter 0. stall_o=0 combinationally after reset.
- Control latency: decode in cycle N appears on ex_* in N+1.
- stall_o is combinational from the ID/EX state, FSM state, inst_i and hold_i. It has no path from flush_i.
- MULDIV occupies EX for exactly MD_LAT cycles; stall_o is high for MD_LAT-1 of them.
- Counter width: clog2(MD_LAT) bits, minimum 1.
- rst_i asserted mid-BUSY aborts the op; the next cycle is IDLE with a bubble in ID/EX.

## Configuration
- CTRL_MULDIV_EN defined: funct7=0000001 R-type decodes as MULDIV (aluop 110, regwrite), and the FSM and counter are present.
- CTRL_MULDIV_EN undefined: such instructions decode as illegal (bubble, illegal_o=1). The FSM is absent, ex_md_busy_o is tied to 0 and MD_LAT is ignored.

## Structure
- Package ctrl_pkg holds:
  - opcode constants
  - the aluop encoding as an enum
  - the ctrl bundle packed struct (7 bits + aluop)
  - the BUBBLE constant
- Sub-module ctrl_decode: pure combinational inst -> bundle, rs-used flags and illegal. The top holds the ID/EX register, hazard logic and FSM.

## Test plan
- Reset, then LOAD x5 followed by ADD x6,x5,x1 -> stall_o=1 for 1 cycle, bubble in EX, ADD reaches EX one cycle later.
- LOAD x0 then ADD using x0 -> no stall.
- BEQ in EX with flush_i=1 while ID holds SW -> ex_memwrite_o=0 next cycle, stall_o=0.
- MUL with MD_LAT=4 -> ex_md_busy_o high 3 cycles, stall_o high 3 cycles, ex_aluop_o=110 held 4 cycles. hold_i=1 for 2 cycles mid-op extends the op to 6 cycles.
- Opcode 7'b1111111 -> illegal_o=1 the next cycle, all ex_* 0. With CTRL_MULDIV_EN undefined, MUL also gives illegal_o=1.
- rst_i asserted during BUSY -> next cycle ex_md_busy_o=0, all outputs 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the ID-stage control unit.
//   - RV32 base opcode constants and funct7 values used by the decoder
//   - aluop_e: the 3-bit ALU operation class handed to EX
//   - ctrl_t: packed control bundle (7 control bits + aluop)
//   - BUBBLE: the all-zero bundle loaded on stall/flush/reset
//   - md_state_e: multi-cycle sequencer state, also exported for debug
//   - funct legality helpers shared by the decoder
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;  // SUB / SRA / SRAI
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    ALU_R    = 3'b000,
    ALU_I    = 3'b001,
    ALU_ADDR = 3'b010,
    ALU_BR   = 3'b011,
    ALU_LUI  = 3'b100,
    ALU_PC   = 3'b101,
    ALU_MD   = 3'b110
  } aluop_e;

  typedef struct packed {
    logic   alusrc;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   branch;
    logic   jump;
    aluop_e aluop;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{
    alusrc: 1'b0, regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0,
    memtoreg: 1'b0, branch: 1'b0, jump: 1'b0, aluop: ALU_R
  };

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Base R-type: funct7 must be zero, except SUB (f3=000) and SRA (f3=101).
  function automatic logic r_funct_ok(logic [2:0] f3, logic [6:0] f7);
    return (f7 == F7_BASE) ||
           ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
  endfunction

  // I-type shifts carry a funct7 field; other I-type ops use it as immediate.
  function automatic logic i_funct_ok(logic [2:0] f3, logic [6:0] f7);
    case (f3)
      3'b001:  return (f7 == F7_BASE);
      3'b101:  return (f7 == F7_BASE) || (f7 == F7_ALT);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_id_stage_if.sv
// ctrl_id_stage_if: ID-side connection between the IF/ID pipeline register
// and the ID-stage control unit.
//   inst       : instruction held in IF/ID
//   inst_valid : IF/ID holds a real instruction (0 = bubble)
//   hold       : global freeze from the memory system
//   flush      : branch/jump taken, squash the ID instruction
//   stall      : control unit asks upstream to hold PC and IF/ID
//
// Handshake: the instruction in IF/ID is consumed on a rising clock edge
// where inst_valid=1 and stall=0; while stall=1 the master keeps inst and
// inst_valid unchanged. flush is not gated by stall and takes effect on the
// edge it is sampled unless the stage is frozen or a multi-cycle op is
// running.
interface ctrl_id_stage_if;
  logic [31:0] inst;
  logic        inst_valid;
  logic        hold;
  logic        flush;
  logic        stall;

  modport master (output inst, output inst_valid, output hold, output flush,
                  input stall);
  modport slave  (input inst, input inst_valid, input hold, input flush,
                  output stall);
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational RV32 control decoder.
//   inst_valid_i : 0 decodes as a bubble, never illegal
//   opcode_i     : inst[6:0]
//   funct3_i     : inst[14:12]
//   funct7_i     : inst[31:25]
//   ctrl_o       : control bundle (BUBBLE for bubbles and illegal encodings)
//   rs1_used_o   : the instruction reads rs1
//   rs2_used_o   : the instruction reads rs2
//   illegal_o    : unknown opcode or funct combination
// Build option: CTRL_MULDIV_EN enables decoding of funct7=0000001 R-type as
// MULDIV; without it those encodings are illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic       inst_valid_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       rs1_used_o,
  output logic       rs2_used_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o     = BUBBLE;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    illegal_o  = 1'b0;
    if (inst_valid_i) begin
      case (opcode_i)
        OP_R: begin
          if (r_funct_ok(funct3_i, funct7_i)) begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.aluop    = ALU_R;
            rs1_used_o      = 1'b1;
            rs2_used_o      = 1'b1;
          end
`ifdef CTRL_MULDIV_EN
          else if (funct7_i == F7_MULDIV) begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.aluop    = ALU_MD;
            rs1_used_o      = 1'b1;
            rs2_used_o      = 1'b1;
          end
`endif
          else begin
            illegal_o = 1'b1;
          end
        end
        OP_I: begin
          if (i_funct_ok(funct3_i, funct7_i)) begin
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.aluop    = ALU_I;
            rs1_used_o      = 1'b1;
          end else begin
            illegal_o = 1'b1;
          end
        end
        OP_LOAD: begin
          // LB, LH, LW, LBU, LHU
          if ((funct3_i != 3'b011) && (funct3_i[2:1] != 2'b11)) begin
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.memread  = 1'b1;
            ctrl_o.memtoreg = 1'b1;
            ctrl_o.aluop    = ALU_ADDR;
            rs1_used_o      = 1'b1;
          end else begin
            illegal_o = 1'b1;
          end
        end
        OP_STORE: begin
          // SB, SH, SW
          if ((funct3_i[2] == 1'b0) && (funct3_i[1:0] != 2'b11)) begin
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.memwrite = 1'b1;
            ctrl_o.aluop    = ALU_ADDR;
            rs1_used_o      = 1'b1;
            rs2_used_o      = 1'b1;
          end else begin
            illegal_o = 1'b1;
          end
        end
        OP_BRANCH: begin
          // funct3 010 and 011 are unassigned
          if (funct3_i[2:1] != 2'b01) begin
            ctrl_o.branch = 1'b1;
            ctrl_o.aluop  = ALU_BR;
            rs1_used_o    = 1'b1;
            rs2_used_o    = 1'b1;
          end else begin
            illegal_o = 1'b1;
          end
        end
        OP_JAL: begin
          ctrl_o.jump     = 1'b1;
          ctrl_o.regwrite = 1'b1;
          ctrl_o.aluop    = ALU_PC;
        end
        OP_JALR: begin
          if (funct3_i == 3'b000) begin
            ctrl_o.jump     = 1'b1;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.aluop    = ALU_PC;
            rs1_used_o      = 1'b1;
          end else begin
            illegal_o = 1'b1;
          end
        end
        OP_LUI: begin
          ctrl_o.alusrc   = 1'b1;
          ctrl_o.regwrite = 1'b1;
          ctrl_o.aluop    = ALU_LUI;
        end
        OP_AUIPC: begin
          ctrl_o.alusrc   = 1'b1;
          ctrl_o.regwrite = 1'b1;
          ctrl_o.aluop    = ALU_PC;
        end
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_id_stage.sv
// ctrl_id_stage: ID-stage control unit for the pipelined RV32 core.
// Decodes the ID instruction (via ctrl_decode), owns the ID/EX control
// register, raises the load-use stall and sequences multi-cycle MUL/DIV ops.
//   Parameters: REG_AW register-address width, MD_LAT EX latency of MUL/DIV
//               (1..16)
//   clk_i, rst_i  : clock, synchronous active-high reset
//   id_if         : ID-side bundle (inst, inst_valid, hold, flush in; stall out)
//   ex_*_o        : registered control bundle of the EX instruction
//   ex_rd_o       : destination register of the EX instruction (0 if none)
//   ex_md_busy_o  : multi-cycle op in progress
//   illegal_o     : registered; last instruction loaded was illegal
//   md_state_o    : sequencer state, for observation
// Build option: CTRL_MULDIV_EN adds MULDIV decode plus the busy sequencer;
// without it ex_md_busy_o is 0, md_state_o is MD_IDLE and MD_LAT is unused.
module ctrl_id_stage
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ctrl_id_stage_if.slave    id_if,
  output logic [2:0]        ex_aluop_o,
  output logic              ex_alusrc_o,
  output logic              ex_regwrite_o,
  output logic              ex_memread_o,
  output logic              ex_memwrite_o,
  output logic              ex_memtoreg_o,
  output logic              ex_branch_o,
  output logic              ex_jump_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_md_busy_o,
  output logic              illegal_o,
  output md_state_e         md_state_o
);

  ctrl_t             dec_ctrl;
  logic              dec_rs1_used;
  logic              dec_rs2_used;
  logic              dec_illegal;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;

  ctrl_t             ex_ctrl_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              illegal_q;

  logic              md_busy;
  logic              load_use;
  logic              advance_en;

  ctrl_decode u_decode (
    .inst_valid_i (id_if.inst_valid),
    .opcode_i     (id_if.inst[6:0]),
    .funct3_i     (id_if.inst[14:12]),
    .funct7_i     (id_if.inst[31:25]),
    .ctrl_o       (dec_ctrl),
    .rs1_used_o   (dec_rs1_used),
    .rs2_used_o   (dec_rs2_used),
    .illegal_o    (dec_illegal)
  );

  assign id_rd  = REG_AW'(id_if.inst[11:7]);
  assign id_rs1 = REG_AW'(id_if.inst[19:15]);
  assign id_rs2 = REG_AW'(id_if.inst[24:20]);

  // Load in EX whose result a used source of the ID instruction needs.
  // The used-flags are already zero for bubbles, so inst_valid is implied.
  always_comb begin
    load_use = 1'b0;
    if (ex_ctrl_q.memread && (ex_rd_q != '0)) begin
      load_use = (dec_rs1_used && (id_rs1 == ex_rd_q)) ||
                 (dec_rs2_used && (id_rs2 == ex_rd_q));
    end
  end

  // ID/EX may change only when neither frozen nor sequencing a MUL/DIV.
  assign advance_en = !id_if.hold && !md_busy;

  // flush is deliberately absent: stall must not depend on it.
  assign id_if.stall = id_if.hold || md_busy || load_use;

  // ID/EX control register. Bubble on flush or load-use; rd is recorded only
  // for instructions that write a register so EX never sees a stale rd.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_ctrl_q <= BUBBLE;
      ex_rd_q   <= '0;
      illegal_q <= 1'b0;
    end else if (advance_en) begin
      if (id_if.flush || load_use) begin
        ex_ctrl_q <= BUBBLE;
        ex_rd_q   <= '0;
        illegal_q <= 1'b0;
      end else begin
        ex_ctrl_q <= dec_ctrl;
        ex_rd_q   <= dec_ctrl.regwrite ? id_rd : '0;
        illegal_q <= dec_illegal;
      end
    end
  end

`ifdef CTRL_MULDIV_EN
  // The op occupies EX for MD_LAT cycles: one BUSY cycle per count from
  // MD_LAT-2 down to 0, then a final IDLE cycle in which ID/EX advances.
  localparam int unsigned CNT_W       = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam int unsigned CNT_INIT    = (MD_LAT > 1) ? (MD_LAT - 2) : 0;
  localparam bit          MD_MULTI    = (MD_LAT > 1);

  md_state_e          md_state_q;
  md_state_e          md_state_d;
  logic [CNT_W-1:0]   md_cnt_q;
  logic [CNT_W-1:0]   md_cnt_d;
  logic               md_start;

  assign md_start = MD_MULTI && advance_en && !id_if.flush && !load_use &&
                    (dec_ctrl.aluop == ALU_MD);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      md_state_q <= MD_IDLE;
      md_cnt_q   <= '0;
    end else if (!id_if.hold) begin
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
    end
  end

  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    case (md_state_q)
      MD_IDLE: begin
        if (md_start) begin
          md_state_d = MD_BUSY;
          md_cnt_d   = CNT_W'(CNT_INIT);
        end
      end
      MD_BUSY: begin
        if (md_cnt_q == '0) begin
          md_state_d = MD_IDLE;
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
        end
      end
      default: begin
        md_state_d = MD_IDLE;
        md_cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    md_busy    = (md_state_q == MD_BUSY);
    md_state_o = md_state_q;
  end
`else
  logic unused_md_lat;

  assign md_busy       = 1'b0;
  assign md_state_o    = MD_IDLE;
  assign unused_md_lat = ^MD_LAT;
`endif

  assign ex_aluop_o    = ex_ctrl_q.aluop;
  assign ex_alusrc_o   = ex_ctrl_q.alusrc;
  assign ex_regwrite_o = ex_ctrl_q.regwrite;
  assign ex_memread_o  = ex_ctrl_q.memread;
  assign ex_memwrite_o = ex_ctrl_q.memwrite;
  assign ex_memtoreg_o = ex_ctrl_q.memtoreg;
  assign ex_branch_o   = ex_ctrl_q.branch;
  assign ex_jump_o     = ex_ctrl_q.jump;
  assign ex_rd_o       = ex_rd_q;
  assign ex_md_busy_o  = md_busy;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_ctrl_id_stage.sv
// tb_ctrl_id_stage: directed bench for ctrl_id_stage with a per-cycle
// reference model of the EX-stage contents and stall behaviour.
module tb_ctrl_id_stage;
  import ctrl_pkg::*;

  localparam int MD_LAT = 4;

  // Hand-assembled instructions
  localparam logic [31:0] I_LW_X5   = 32'h0001_2283; // lw   x5,0(x2)
  localparam logic [31:0] I_LW_X0   = 32'h0001_2003; // lw   x0,0(x2)
  localparam logic [31:0] I_ADD_X5  = 32'h0012_8333; // add  x6,x5,x1
  localparam logic [31:0] I_ADD_X0  = 32'h0010_0333; // add  x6,x0,x1
  localparam logic [31:0] I_BEQ     = 32'h0020_8063; // beq  x1,x2,0
  localparam logic [31:0] I_SW      = 32'h0051_2023; // sw   x5,0(x2)
  localparam logic [31:0] I_MUL     = 32'h0262_83B3; // mul  x7,x5,x6
  localparam logic [31:0] I_BAD     = 32'h0000_007F; // opcode 1111111
  localparam logic [31:0] I_ADDI    = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_LUI     = 32'h0000_11B7; // lui  x3,1
  localparam logic [31:0] I_JAL     = 32'h0000_00EF; // jal  x1,0
  localparam logic [31:0] I_JALR_X5 = 32'h0002_80E7; // jalr x1,0(x5)
  localparam logic [31:0] I_AUIPC   = 32'h0000_1217; // auipc x4,1

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_id_stage_if id_if ();

  logic [2:0] ex_aluop_o;
  logic       ex_alusrc_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o;
  logic       ex_memtoreg_o, ex_branch_o, ex_jump_o;
  logic [4:0] ex_rd_o;
  logic       ex_md_busy_o, illegal_o;
  md_state_e  md_state_o;

  ctrl_id_stage #(.REG_AW(5), .MD_LAT(MD_LAT)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_if         (id_if.slave),
    .ex_aluop_o    (ex_aluop_o),
    .ex_alusrc_o   (ex_alusrc_o),
    .ex_regwrite_o (ex_regwrite_o),
    .ex_memread_o  (ex_memread_o),
    .ex_memwrite_o (ex_memwrite_o),
    .ex_memtoreg_o (ex_memtoreg_o),
    .ex_branch_o   (ex_branch_o),
    .ex_jump_o     (ex_jump_o),
    .ex_rd_o       (ex_rd_o),
    .ex_md_busy_o  (ex_md_busy_o),
    .illegal_o     (illegal_o),
    .md_state_o    (md_state_o)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ctl order: {alusrc, regwrite, memread, memwrite, memtoreg, branch, jump}
  typedef struct packed {
    logic [6:0] ctl;
    logic [2:0] aluop;
    logic [4:0] rd;
    logic       illegal;
    logic       rs1u;
    logic       rs2u;
  } dec_t;

  function automatic dec_t ref_decode(input logic [31:0] inst,
                                      input logic valid);
    dec_t d;
    logic ok;
    logic [2:0] f3;
    logic [6:0] f7;
    d  = '0;
    ok = 1'b1;
    f3 = inst[14:12];
    f7 = inst[31:25];
    if (!valid) return d;
    case (inst[6:0])
      7'b0110011: begin
        if (f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))) begin
          d.ctl = 7'b0100000; d.aluop = 3'd0;
        end
`ifdef CTRL_MULDIV_EN
        else if (f7 == 7'b0000001) begin
          d.ctl = 7'b0100000; d.aluop = 3'd6;
        end
`endif
        else ok = 1'b0;
        d.rs1u = 1'b1; d.rs2u = 1'b1;
      end
      7'b0010011: begin
        if (f3 == 3'd1) ok = (f7 == 7'd0);
        if (f3 == 3'd5) ok = (f7 == 7'd0) || (f7 == 7'b0100000);
        d.ctl = 7'b1100000; d.aluop = 3'd1; d.rs1u = 1'b1;
      end
      7'b0000011: begin
        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        d.ctl = 7'b1110100; d.aluop = 3'd2; d.rs1u = 1'b1;
      end
      7'b0100011: begin
        ok = (f3 <= 3'd2);
        d.ctl = 7'b1001000; d.aluop = 3'd2; d.rs1u = 1'b1; d.rs2u = 1'b1;
      end
      7'b1100011: begin
        ok = (f3 != 3'd2 && f3 != 3'd3);
        d.ctl = 7'b0000010; d.aluop = 3'd3; d.rs1u = 1'b1; d.rs2u = 1'b1;
      end
      7'b1101111: begin d.ctl = 7'b0100001; d.aluop = 3'd5; end
      7'b1100111: begin
        ok = (f3 == 3'd0);
        d.ctl = 7'b0100001; d.aluop = 3'd5; d.rs1u = 1'b1;
      end
      7'b0110111: begin d.ctl = 7'b1100000; d.aluop = 3'd4; end
      7'b0010111: begin d.ctl = 7'b1100000; d.aluop = 3'd5; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d = '0;
      d.illegal = 1'b1;
    end else if (d.ctl[5]) begin
      d.rd = inst[11:7];
    end
    return d;
  endfunction

  dec_t m_ex;               // what EX must hold
  int   m_md_left = 0;      // remaining cycles the MUL/DIV keeps ID frozen
  bit   model_on  = 1'b0;

  function automatic logic m_load_use();
    dec_t d;
    d = ref_decode(id_if.inst, id_if.inst_valid);
    return m_ex.ctl[4] && (m_ex.rd != 5'd0) &&
           ((d.rs1u && id_if.inst[19:15] == m_ex.rd) ||
            (d.rs2u && id_if.inst[24:20] == m_ex.rd));
  endfunction

  always @(posedge clk) begin
    dec_t d;
    d = ref_decode(id_if.inst, id_if.inst_valid);
    if (rst) begin
      m_ex      = '0;
      m_md_left = 0;
      model_on  = 1'b1;
    end else if (id_if.hold) begin
      m_ex = m_ex;
    end else if (m_md_left > 0) begin
      m_md_left--;
    end else if (id_if.flush || m_load_use()) begin
      m_ex = '0;
    end else begin
      m_ex = d;
      if (d.aluop == 3'd6 && MD_LAT > 1) m_md_left = MD_LAT - 1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("ex_ctl", {ex_alusrc_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o,
                       ex_memtoreg_o, ex_branch_o, ex_jump_o}, m_ex.ctl);
      check("ex_aluop", ex_aluop_o, m_ex.aluop);
      check("ex_rd", ex_rd_o, m_ex.rd);
      check("illegal", illegal_o, m_ex.illegal);
      check("md_busy", ex_md_busy_o, m_md_left > 0);
      check("md_state", md_state_o == MD_BUSY, m_md_left > 0);
      check("stall", id_if.stall,
            id_if.hold || (m_md_left > 0) || m_load_use());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic [31:0] inst, input logic valid,
                     input logic hold, input logic flush);
    id_if.inst       = inst;
    id_if.inst_valid = valid;
    id_if.hold       = hold;
    id_if.flush      = flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    put(32'h0, 1'b0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  logic [31:0] prog[9] = '{I_ADDI, I_LUI, I_JAL, I_SW, I_BEQ, I_LW_X5,
                           I_ADD_X5, I_AUIPC, I_JALR_X5};

  // ---------------- directed stimulus ----------------
  initial begin
    int n_ex, n_st, n_bz, guard;
    rst = 1'b1;
    put(32'h0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;

    @(negedge clk);
    check("rst_regwrite", ex_regwrite_o, 0);
    check("rst_aluop", ex_aluop_o, 0);
    check("rst_rd", ex_rd_o, 0);
    check("rst_illegal", illegal_o, 0);
    check("rst_stall", id_if.stall, 0);
    check("rst_busy", ex_md_busy_o, 0);
    tick();

    // load-use: one stall cycle, bubble in EX, then ADD
    put(I_LW_X5, 1'b1, 1'b0, 1'b0); tick();
    put(I_ADD_X5, 1'b1, 1'b0, 1'b0);
    @(negedge clk); check("lu_stall", id_if.stall, 1);
    tick();
    @(negedge clk);
    check("lu_bubble_memread", ex_memread_o, 0);
    check("lu_bubble_regwrite", ex_regwrite_o, 0);
    check("lu_stall_released", id_if.stall, 0);
    tick();
    @(negedge clk);
    check("lu_add_rd", ex_rd_o, 6);
    check("lu_add_regwrite", ex_regwrite_o, 1);
    idle(1);

    // load into x0 never stalls
    put(I_LW_X0, 1'b1, 1'b0, 1'b0); tick();
    put(I_ADD_X0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); check("x0_no_stall", id_if.stall, 0);
    tick();
    @(negedge clk); check("x0_add_rd", ex_rd_o, 6);
    idle(1);

    // flush squashes the SW behind a taken BEQ
    put(I_BEQ, 1'b1, 1'b0, 1'b0); tick();
    @(negedge clk); check("beq_branch", ex_branch_o, 1);
    put(I_SW, 1'b1, 1'b0, 1'b1);
    @(negedge clk); check("flush_stall", id_if.stall, 0);
    tick();
    @(negedge clk); check("flush_memwrite", ex_memwrite_o, 0);
    idle(1);

    // unknown opcode
    put(I_BAD, 1'b1, 1'b0, 1'b0); tick();
    @(negedge clk);
    check("bad_illegal", illegal_o, 1);
    check("bad_regwrite", ex_regwrite_o, 0);
    put(I_ADDI, 1'b1, 1'b0, 1'b0); tick();
    @(negedge clk);
    check("bad_cleared", illegal_o, 0);
    check("addi_alusrc", ex_alusrc_o, 1);

    // hold freezes ID/EX with a load in EX
    put(I_LW_X5, 1'b1, 1'b0, 1'b0); tick();
    put(I_ADDI, 1'b1, 1'b1, 1'b0); tick(); tick();
    @(negedge clk);
    check("hold_memread", ex_memread_o, 1);
    check("hold_stall", id_if.stall, 1);
    idle(1);

`ifdef CTRL_MULDIV_EN
    // MUL: 4 cycles in EX, 3 stalled/busy cycles
    put(I_MUL, 1'b1, 1'b0, 1'b0); tick();
    put(I_ADDI, 1'b1, 1'b0, 1'b0);
    n_ex = 0; n_st = 0; n_bz = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ex_aluop_o != 3'b110) break;
      n_ex++;
      if (id_if.stall) n_st++;
      if (ex_md_busy_o) n_bz++;
      tick();
    end
    check("mul_ex_cycles", n_ex, 4);
    check("mul_stall_cycles", n_st, 3);
    check("mul_busy_cycles", n_bz, 3);
    idle(1);

    // two hold cycles mid-op stretch it to 6
    put(I_MUL, 1'b1, 1'b0, 1'b0); tick();
    put(I_ADDI, 1'b1, 1'b0, 1'b0);
    n_ex = 0;
    for (int k = 0; k < 20; k++) begin
      id_if.hold = (k == 1 || k == 2);
      @(negedge clk);
      if (ex_aluop_o != 3'b110) break;
      n_ex++;
      tick();
    end
    id_if.hold = 1'b0;
    check("mul_hold_cycles", n_ex, 6);
    idle(1);

    // reset during BUSY aborts the op
    put(I_MUL, 1'b1, 1'b0, 1'b0); tick();
    put(32'h0, 1'b0, 1'b0, 1'b0); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check("rst_busy_abort", ex_md_busy_o, 0);
    check("rst_busy_aluop", ex_aluop_o, 0);
    check("rst_busy_stall", id_if.stall, 0);
`else
    put(I_MUL, 1'b1, 1'b0, 1'b0); tick();
    @(negedge clk);
    check("mul_illegal", illegal_o, 1);
    check("mul_aluop", ex_aluop_o, 0);
    check("mul_no_busy", ex_md_busy_o, 0);
    idle(1);
    put(I_LW_X5, 1'b1, 1'b0, 1'b0); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check("rst_mid_memread", ex_memread_o, 0);
    check("rst_mid_rd", ex_rd_o, 0);
`endif
    idle(1);

    // program stream; the model checks each cycle, driver respects stall
    foreach (prog[i]) begin
      put(prog[i], 1'b1, 1'b0, 1'b0);
      guard = 0;
      @(negedge clk);
      while (id_if.stall && guard < 40) begin
        tick();
        guard++;
        @(negedge clk);
      end
      if (guard >= 40) check("drain_timeout", 1, 0);
      tick();
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
